// File: rtl/l1c_mem_arbiter_if.sv
// Signal bundle between the two L1 caches, the shared CPU-wrapper memory port
// and the arbiter that multiplexes them.
interface l1c_mem_arbiter_if;
    logic        I_req;
    logic [31:0] I_addr;
    logic        D_req;
    logic        D_write;
    logic [31:0] D_addr;
    logic [31:0] D_in;
    logic [2:0]  D_type;
    logic        RVALID;
    logic        RLAST;
    logic        BVALID;
    logic        BREADY;
    logic        M_req;
    logic        M_write;
    logic [31:0] M_addr;
    logic [31:0] M_in;
    logic [2:0]  M_type;
    logic        I_RVALID;
    logic        I_RLAST;
    logic        D_RVALID;
    logic        D_RLAST;
    logic        D_BVALID;
    logic        I_busy;
    logic [1:0]  grant;
    logic        proto_err;

    // Arbiter side
    modport slave (
        input  I_req, I_addr, D_req, D_write, D_addr, D_in, D_type,
        input  RVALID, RLAST, BVALID, BREADY,
        output M_req, M_write, M_addr, M_in, M_type,
        output I_RVALID, I_RLAST, D_RVALID, D_RLAST, D_BVALID,
        output I_busy, grant, proto_err
    );

    // Requester / memory-model side
    modport master (
        output I_req, I_addr, D_req, D_write, D_addr, D_in, D_type,
        output RVALID, RLAST, BVALID, BREADY,
        input  M_req, M_write, M_addr, M_in, M_type,
        input  I_RVALID, I_RLAST, D_RVALID, D_RLAST, D_BVALID,
        input  I_busy, grant, proto_err
    );
endinterface

// File: rtl/l1c_mem_arbiter.sv
// Two-requester arbiter for the shared memory port: I-cache reads vs D-cache
// reads/writes, one grant at a time, held until the transaction completes.
module l1c_mem_arbiter #(
    parameter int MAX_BEATS = 4,
    parameter bit RR_EN     = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    l1c_mem_arbiter_if.slave   bus
);
    localparam int CNT_W = $clog2(MAX_BEATS) + 1;

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_last_grant;   // 0 = I, 1 = D
    logic [31:0]        r_addr;
    logic               r_write;
    logic [31:0]        r_in;
    logic [2:0]         r_type;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic               r_proto_err;

    logic               w_i_pend;
    logic               w_d_pend;
    logic               w_win_i;
    logic               w_win_d;
    logic               w_granted;
    logic               w_done;
    logic               w_read_beat;
    logic [1:0]         w_grant;

    assign w_i_pend = bus.I_req;
    assign w_d_pend = bus.D_req | bus.D_write;

    // Winner selection only matters in IDLE; on a tie round-robin picks the
    // side that did not win last time.
    always_comb begin
        w_win_i = 1'b0;
        w_win_d = 1'b0;
        if (r_state == IDLE) begin
            if (w_i_pend && w_d_pend) begin
                w_win_d = RR_EN ? (r_last_grant == 1'b0) : 1'b1;
                w_win_i = ~w_win_d;
            end else begin
                w_win_i = w_i_pend;
                w_win_d = w_d_pend;
            end
        end
    end

    assign w_granted   = (r_state == GRANT_I) || (r_state == GRANT_D);
    assign w_read_beat = w_granted && !r_write && bus.RVALID;
    assign w_done      = w_granted && (r_write ? (bus.BVALID && bus.BREADY)
                                               : (bus.RVALID && bus.RLAST));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_win_d)      w_state_next = GRANT_D;
                else if (w_win_i) w_state_next = GRANT_I;
            end
            GRANT_I, GRANT_D: begin
                if (w_done) w_state_next = RELEASE;
            end
            RELEASE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b0;
            r_addr       <= '0;
            r_write      <= 1'b0;
            r_in         <= '0;
            r_type       <= '0;
            r_beat_cnt   <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_win_d) begin
                r_last_grant <= 1'b1;
                r_addr       <= bus.D_addr;
                r_write      <= bus.D_write;
                r_in         <= bus.D_in;
                r_type       <= bus.D_type;
            end else if (w_win_i) begin
                r_last_grant <= 1'b0;
                r_addr       <= bus.I_addr;
                r_write      <= 1'b0;
                r_in         <= '0;
                r_type       <= '0;
            end
            // Counter saturates at MAX_BEATS so every further stray beat is still flagged.
            if (r_state == RELEASE) begin
                r_beat_cnt <= '0;
            end else if (w_read_beat && (r_beat_cnt != CNT_W'(MAX_BEATS))) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            if (w_read_beat && !bus.RLAST && (r_beat_cnt == CNT_W'(MAX_BEATS))) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign w_grant = {(r_state == GRANT_D), (r_state == GRANT_I)};

    assign bus.grant     = w_grant;
    assign bus.M_req     = w_granted && !r_write;
    assign bus.M_write   = w_granted && r_write;
    assign bus.M_addr    = w_granted ? r_addr : 32'h0;
    assign bus.M_in      = w_granted ? r_in   : 32'h0;
    assign bus.M_type    = w_granted ? r_type : 3'h0;
    assign bus.I_RVALID  = bus.RVALID & w_grant[0];
    assign bus.I_RLAST   = bus.RLAST  & w_grant[0];
    assign bus.D_RVALID  = bus.RVALID & w_grant[1];
    assign bus.D_RLAST   = bus.RLAST  & w_grant[1];
    assign bus.D_BVALID  = bus.BVALID & bus.BREADY & w_grant[1];
    assign bus.I_busy    = w_grant[0] | w_win_i;
    assign bus.proto_err = r_proto_err;
endmodule

// File: tb/tb_l1c_mem_arbiter.sv
// Directed bench for l1c_mem_arbiter: per-cycle vector table plus hand-written
// multi-cycle sequences on a round-robin and a fixed-priority instance.
module tb_l1c_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    l1c_mem_arbiter_if b1();
    l1c_mem_arbiter_if b2();

    l1c_mem_arbiter #(.MAX_BEATS(4), .RR_EN(1'b1)) dut1 (.clk(clk), .rst(rst),  .bus(b1));
    l1c_mem_arbiter #(.MAX_BEATS(4), .RR_EN(1'b0)) dut2 (.clk(clk), .rst(rst2), .bus(b2));

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_write;
        logic [31:0] d_addr;
        logic [31:0] d_in;
        logic [2:0]  d_type;
        logic        rvalid, rlast, bvalid, bready;
        logic [77:0] exp;
    } vec_t;

    vec_t vt[16];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    function automatic logic [77:0] ex(input logic [1:0] g, input logic mreq, input logic mwr,
                                       input logic [31:0] maddr, input logic [31:0] min,
                                       input logic [2:0] mtype, input logic irv, input logic irl,
                                       input logic drv, input logic drl, input logic db,
                                       input logic ibusy, input logic perr);
        return {g, mreq, mwr, maddr, min, mtype, irv, irl, drv, drl, db, ibusy, perr};
    endfunction

    function automatic vec_t mk(input string name, input logic ir, input logic [31:0] ia,
                                input logic dr, input logic dw, input logic [31:0] da,
                                input logic [31:0] di, input logic [2:0] dt,
                                input logic rv, input logic rl, input logic bv, input logic br,
                                input logic [77:0] e);
        vec_t v;
        v.name = name; v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_write = dw;
        v.d_addr = da; v.d_in = di; v.d_type = dt;
        v.rvalid = rv; v.rlast = rl; v.bvalid = bv; v.bready = br; v.exp = e;
        return v;
    endfunction

    function automatic logic [77:0] obs1();
        return {b1.grant, b1.M_req, b1.M_write, b1.M_addr, b1.M_in, b1.M_type,
                b1.I_RVALID, b1.I_RLAST, b1.D_RVALID, b1.D_RLAST, b1.D_BVALID,
                b1.I_busy, b1.proto_err};
    endfunction

    task automatic clear1();
        b1.I_req = 0; b1.I_addr = 0; b1.D_req = 0; b1.D_write = 0; b1.D_addr = 0;
        b1.D_in = 0; b1.D_type = 0; b1.RVALID = 0; b1.RLAST = 0; b1.BVALID = 0; b1.BREADY = 0;
    endtask

    task automatic wait_grant1(output logic [1:0] g);
        logic seen;
        seen = 1'b0;
        g = 2'b00;
        for (int n = 0; n < 12 && !seen; n++) begin
            @(negedge clk); #1;
            if (b1.grant != 2'b00) begin g = b1.grant; seen = 1'b1; end
        end
    endtask

    task automatic pulse_rst1();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        logic [1:0] g;
        logic [1:0] exp_order [4];
        int ibusy_hits;

        clear1();
        b2.I_req = 0; b2.I_addr = 0; b2.D_req = 0; b2.D_write = 0; b2.D_addr = 0;
        b2.D_in = 0; b2.D_type = 0; b2.RVALID = 0; b2.RLAST = 0; b2.BVALID = 0; b2.BREADY = 0;

        // Per-cycle vectors: inputs during the cycle, expected outputs before the clock edge.
        vt[0]  = mk("c0_idle_ireq",   1, 32'h0000_1230, 0,0, 0,0,0, 0,0,0,0, ex(2'b00,0,0,0,0,0, 0,0,0,0,0, 1,0));
        vt[1]  = mk("c1_gi_beat1",    0, 0,             0,0, 0,0,0, 1,0,0,0, ex(2'b01,1,0,32'h1230,0,0, 1,0,0,0,0, 1,0));
        vt[2]  = mk("c2_gi_gap",      0, 0,             0,0, 0,0,0, 0,0,0,0, ex(2'b01,1,0,32'h1230,0,0, 0,0,0,0,0, 1,0));
        vt[3]  = mk("c3_gi_beat2",    0, 0,             0,0, 0,0,0, 1,0,0,0, ex(2'b01,1,0,32'h1230,0,0, 1,0,0,0,0, 1,0));
        vt[4]  = mk("c4_gi_beat3",    0, 0,             0,0, 0,0,0, 1,0,0,0, ex(2'b01,1,0,32'h1230,0,0, 1,0,0,0,0, 1,0));
        vt[5]  = mk("c5_gi_last_dw",  0, 0,             0,1, 32'h2000_0008,32'hDEADBEEF,3'd2, 1,1,0,0, ex(2'b01,1,0,32'h1230,0,0, 1,1,0,0,0, 1,0));
        vt[6]  = mk("c6_release",     0, 0,             0,1, 32'h2000_0008,32'hDEADBEEF,3'd2, 0,0,0,0, ex(2'b00,0,0,0,0,0, 0,0,0,0,0, 0,0));
        vt[7]  = mk("c7_idle_dw",     0, 0,             0,1, 32'h2000_0008,32'hDEADBEEF,3'd2, 0,0,0,0, ex(2'b00,0,0,0,0,0, 0,0,0,0,0, 0,0));
        vt[8]  = mk("c8_gd_write",    0, 0,             0,0, 0,0,0, 0,0,0,0, ex(2'b10,0,1,32'h2000_0008,32'hDEADBEEF,3'd2, 0,0,0,0,0, 0,0));
        vt[9]  = mk("c9_gd_bv_nordy", 0, 0,             0,0, 0,0,0, 0,0,1,0, ex(2'b10,0,1,32'h2000_0008,32'hDEADBEEF,3'd2, 0,0,0,0,0, 0,0));
        vt[10] = mk("c10_gd_wait",    0, 0,             0,0, 0,0,0, 0,0,0,0, ex(2'b10,0,1,32'h2000_0008,32'hDEADBEEF,3'd2, 0,0,0,0,0, 0,0));
        vt[11] = mk("c11_gd_bresp",   0, 0,             0,0, 0,0,0, 0,0,1,1, ex(2'b10,0,1,32'h2000_0008,32'hDEADBEEF,3'd2, 0,0,0,0,1, 0,0));
        vt[12] = mk("c12_rel_ireq",   1, 32'h0000_5678, 0,0, 0,0,0, 0,0,0,0, ex(2'b00,0,0,0,0,0, 0,0,0,0,0, 0,0));
        vt[13] = mk("c13_idle_ireq",  1, 32'h0000_5678, 0,0, 0,0,0, 0,0,0,0, ex(2'b00,0,0,0,0,0, 0,0,0,0,0, 1,0));
        vt[14] = mk("c14_gi_single",  0, 0,             0,0, 0,0,0, 1,1,0,0, ex(2'b01,1,0,32'h5678,0,0, 1,1,0,0,0, 1,0));
        vt[15] = mk("c15_release",    0, 0,             0,0, 0,0,0, 0,0,0,0, ex(2'b00,0,0,0,0,0, 0,0,0,0,0, 0,0));

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", {50'h0, obs1()}, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        rst2 = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            b1.I_req = vt[i].i_req; b1.I_addr = vt[i].i_addr;
            b1.D_req = vt[i].d_req; b1.D_write = vt[i].d_write;
            b1.D_addr = vt[i].d_addr; b1.D_in = vt[i].d_in; b1.D_type = vt[i].d_type;
            b1.RVALID = vt[i].rvalid; b1.RLAST = vt[i].rlast;
            b1.BVALID = vt[i].bvalid; b1.BREADY = vt[i].bready;
            #1;
            check(vt[i].name, {50'h0, obs1()}, {50'h0, vt[i].exp});
        end
        clear1();

        // Round-robin with both requests held: D, I, D, I from reset.
        pulse_rst1();
        exp_order[0] = 2'b10; exp_order[1] = 2'b01; exp_order[2] = 2'b10; exp_order[3] = 2'b01;
        b1.I_req = 1; b1.D_req = 1;
        for (int k = 0; k < 4; k++) begin
            wait_grant1(g);
            check($sformatf("rr_grant%0d", k), {126'h0, g}, {126'h0, exp_order[k]});
            b1.RVALID = 1; b1.RLAST = 1;
            @(negedge clk);
            b1.RVALID = 0; b1.RLAST = 0;
        end
        clear1();

        // Fixed priority instance: D every time, I_busy never set.
        b2.I_req = 1; b2.D_req = 1;
        ibusy_hits = 0;
        for (int k = 0; k < 4; k++) begin
            logic seen;
            seen = 1'b0;
            for (int n = 0; n < 12 && !seen; n++) begin
                @(negedge clk); #1;
                if (b2.I_busy) ibusy_hits++;
                if (b2.grant != 2'b00) seen = 1'b1;
            end
            check($sformatf("fp_grant%0d", k), {126'h0, b2.grant}, {126'h0, 2'b10});
            b2.RVALID = 1; b2.RLAST = 1;
            @(negedge clk); #1;
            if (b2.I_busy) ibusy_hits++;
            b2.RVALID = 0; b2.RLAST = 0;
        end
        check("fp_ibusy_never", 128'(ibusy_hits), 128'h0);
        b2.I_req = 0; b2.D_req = 0;

        // Over-long burst: proto_err rises on the 5th beat, grant held until RLAST.
        pulse_rst1();
        b1.I_req = 1; b1.I_addr = 32'h0000_0040;
        wait_grant1(g);
        check("perr_grant", {126'h0, g}, {126'h0, 2'b01});
        b1.I_req = 0;
        b1.RVALID = 1; b1.RLAST = 0;
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk); #1;
            if (k == 5) check("perr_after4", {127'h0, b1.proto_err}, 128'h0);
            if (k == 6) begin
                check("perr_after5", {127'h0, b1.proto_err}, 128'h1);
                check("perr_grant_held", {126'h0, b1.grant}, {126'h0, 2'b01});
            end
            b1.RVALID = 1; b1.RLAST = (k == 6);
        end
        @(negedge clk);
        b1.RVALID = 0; b1.RLAST = 0;
        #1;
        check("perr_release", {125'h0, b1.grant, b1.proto_err}, {125'h0, 2'b00, 1'b1});
        @(negedge clk); #1;
        check("perr_sticky", {127'h0, b1.proto_err}, 128'h1);

        // Asynchronous reset in the middle of a D read burst.
        b1.D_req = 1; b1.D_addr = 32'h3000_0000;
        wait_grant1(g);
        check("rst_pre_grant", {126'h0, g}, {126'h0, 2'b10});
        b1.D_req = 0; b1.RVALID = 1;
        @(negedge clk);
        b1.RVALID = 0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", {50'h0, obs1()}, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        b1.I_req = 1; b1.I_addr = 32'h4000_0000;
        #1;
        check("rst_idle_ibusy", {127'h0, b1.I_busy}, 128'h1);
        wait_grant1(g);
        check("rst_next_igrant", {94'h0, g, b1.M_req, b1.M_addr}, {94'h0, 2'b01, 1'b1, 32'h4000_0000});
        b1.I_req = 0; b1.RVALID = 1; b1.RLAST = 1;
        @(negedge clk);
        clear1();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
